// File: rtl/serial_sum_deserializer.sv
// Reassembles the LSB-first serial sum stream into a WIDTH-bit word behind a valid/ready handshake.
// Define SERIAL_DESER_OVF_EN to capture the final adder carry into ovf; otherwise ovf is tied to 0.
module serial_sum_deserializer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bit_en,
   input  logic             sum_bit,
   input  logic             carry_in,
   input  logic             frame_start,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum_out,
   output logic             ovf,
   output logic             busy,
   output logic             frame_err
);

   localparam int               CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sh;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] sh_next;
   logic             start_bit;
   logic             data_bit;
   logic             last_bit;

   // New bits enter at the MSB so that after WIDTH captures bit 0 sits in sh[0].
   assign sh_next   = {sum_bit, sh[WIDTH-1:1]};
   assign start_bit = bit_en & frame_start;
   assign data_bit  = bit_en & ~frame_start;
   assign last_bit  = (state == SHIFT) && data_bit && (cnt == LAST_CNT);

   assign sum_out = sh;

   // NOTE: every register here uses non-blocking assignment so all state updates see pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         sh        <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               if (start_bit) begin
                  sh    <= sh_next;
                  cnt   <= CNT_W'(1);
                  state <= SHIFT;
                  busy  <= 1'b1;
               end else if (data_bit) begin
                  frame_err <= 1'b1;
               end
            end

            SHIFT: begin
               if (bit_en) begin
                  sh <= sh_next;
                  if (frame_start) begin
                     // A fresh frame_start abandons the partial word and restarts at bit 0.
                     frame_err <= 1'b1;
                     cnt       <= CNT_W'(1);
                  end else if (last_bit) begin
                     cnt       <= cnt + CNT_W'(1);
                     state     <= HOLD;
                     busy      <= 1'b0;
                     out_valid <= 1'b1;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end

            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (start_bit) begin
                     // Handshake and next word's bit 0 share this edge: no bubble.
                     sh    <= sh_next;
                     cnt   <= CNT_W'(1);
                     state <= SHIFT;
                     busy  <= 1'b1;
                  end else begin
                     cnt       <= '0;
                     state     <= IDLE;
                     frame_err <= data_bit;
                  end
               end else if (bit_en) begin
                  frame_err <= 1'b1;
               end
            end

            default: begin
               state     <= IDLE;
               cnt       <= '0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

`ifdef SERIAL_DESER_OVF_EN
   logic ovf_q;
   logic handshake;

   assign handshake = (state == HOLD) && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (last_bit) begin
         ovf_q <= carry_in;
      end else if (handshake) begin
         ovf_q <= 1'b0;
      end
   end

   assign ovf = ovf_q;
`else
   logic unused_carry;

   assign unused_carry = carry_in;
   assign ovf          = 1'b0;
`endif

endmodule

// File: tb/tb_serial_sum_deserializer.sv
// Self-checking bench for serial_sum_deserializer: directed scenarios plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_serial_sum_deserializer;

   localparam int W = 8;
`ifdef SERIAL_DESER_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic         clk;
   logic         rst_n;
   logic         bit_en;
   logic         sum_bit;
   logic         carry_in;
   logic         frame_start;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum_out;
   logic         ovf;
   logic         busy;
   logic         frame_err;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   // Behavioural model: received bits of the word in progress/held, plus status flags.
   bit q_bits[$];
   bit m_valid;
   bit m_busy;
   bit m_ferr;
   bit m_ovf;

   serial_sum_deserializer #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bit_en      (bit_en),
      .sum_bit     (sum_bit),
      .carry_in    (carry_in),
      .frame_start (frame_start),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .sum_out     (sum_out),
      .ovf         (ovf),
      .busy        (busy),
      .frame_err   (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_word();
      logic [31:0] w = '0;
      foreach (q_bits[i]) w[i] = q_bits[i];
      return w;
   endfunction

   task automatic model_reset();
      q_bits.delete();
      m_valid = 1'b0;
      m_busy  = 1'b0;
      m_ferr  = 1'b0;
      m_ovf   = 1'b0;
   endtask

   task automatic model_step(input bit be, input bit sb, input bit ci, input bit fs, input bit rdy);
      m_ferr = 1'b0;
      if (m_valid) begin
         if (rdy) begin
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            q_bits.delete();
            if (be && fs) begin
               q_bits.push_back(sb);
               m_busy = 1'b1;
            end else if (be) begin
               m_ferr = 1'b1;
            end
         end else if (be) begin
            m_ferr = 1'b1;
         end
      end else if (m_busy) begin
         if (be) begin
            if (fs) begin
               m_ferr = 1'b1;
               q_bits.delete();
            end
            q_bits.push_back(sb);
            if (q_bits.size() == W) begin
               m_busy  = 1'b0;
               m_valid = 1'b1;
               m_ovf   = OVF_EN ? ci : 1'b0;
            end
         end
      end else if (be) begin
         if (fs) begin
            q_bits.push_back(sb);
            m_busy = 1'b1;
         end else begin
            m_ferr = 1'b1;
         end
      end
   endtask

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         logic [31:0] exp_word;
         check("out_valid", 32'(out_valid), 32'(m_valid));
         check("busy", 32'(busy), 32'(m_busy));
         check("frame_err", 32'(frame_err), 32'(m_ferr));
         check("ovf", 32'(ovf), 32'(m_ovf));
         if (m_valid) begin
            exp_word = model_word();
            check("sum_out", 32'(sum_out), exp_word);
         end
      end
   end

   // One clock: drive inputs, let the edge happen, step the model, return at the next negedge.
   task automatic cyc(input bit be, input bit sb, input bit ci, input bit fs, input bit rdy);
      bit_en      = be;
      sum_bit     = sb;
      carry_in    = ci;
      frame_start = fs;
      out_ready   = rdy;
      @(posedge clk);
      model_step(be, sb, ci, fs, rdy);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bit_en      = 1'b0;
      sum_bit     = 1'b0;
      carry_in    = 1'b0;
      frame_start = 1'b0;
      out_ready   = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Sends all W bits of a word; gap inserts an idle cycle after each bit except the last.
   task automatic send_word(input logic [W-1:0] val, input bit gap, input bit rdy, input bit last_carry);
      for (int i = 0; i < W; i++) begin
         cyc(1'b1, val[i], (i == W - 1) ? last_carry : 1'b0, i == 0, rdy);
         if (gap && i != W - 1) cyc(1'b0, 1'b0, 1'b0, 1'b0, rdy);
      end
   endtask

   task automatic expect_word(input string name, input logic [W-1:0] val);
      check({name, "_valid"}, 32'(out_valid), 32'd1);
      check({name, "_sum"}, 32'(sum_out), 32'(val));
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      model_reset();
      @(negedge clk);
      #2;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_sum", 32'(sum_out), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_ferr", 32'(frame_err), 32'd0);
      do_reset();
      cmp_en = 1'b1;
      @(negedge clk);

      // Stray bit in IDLE: frame_err pulses once, nothing captured.
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check("idle_stray_ferr", 32'(frame_err), 32'd1);
      check("idle_stray_valid", 32'(out_valid), 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("idle_stray_ferr_end", 32'(frame_err), 32'd0);

      // Contiguous 0xA5, consumer always ready: valid for exactly one cycle.
      send_word(8'hA5, 1'b0, 1'b1, 1'b0);
      expect_word("a5", 8'hA5);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("a5_valid_drop", 32'(out_valid), 32'd0);

      // Gapped 0x3C: 15 cycles, busy high until completion.
      for (int i = 0; i < W; i++) begin
         logic [W-1:0] v = 8'h3C;
         cyc(1'b1, v[i], 1'b0, i == 0, 1'b0);
         if (i != W - 1) begin
            check("gap_busy", 32'(busy), 32'd1);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            check("gap_busy_idle", 32'(busy), 32'd1);
         end
      end
      expect_word("3c", 8'h3C);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Backpressure on 0x5A with a stray bit during HOLD.
      send_word(8'h5A, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cyc(i == 2, 1'b1, 1'b0, 1'b0, 1'b0);
         check("bp_sum", 32'(sum_out), 32'h5A);
         check("bp_ferr", 32'(frame_err), (i == 2) ? 32'd1 : 32'd0);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("bp_valid_drop", 32'(out_valid), 32'd0);

      // Three-bit partial word abandoned by a new frame_start carrying 0x81.
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, i == 0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      check("restart_ferr", 32'(frame_err), 32'd1);
      for (int i = 1; i < W; i++) begin
         logic [W-1:0] v = 8'h81;
         cyc(1'b1, v[i], 1'b0, 1'b0, 1'b0);
         check("restart_ferr_quiet", 32'(frame_err), 32'd0);
      end
      expect_word("81", 8'h81);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Back-to-back 0x12 then 0x34, frame_start on the handshake cycle.
      send_word(8'h12, 1'b0, 1'b1, 1'b0);
      expect_word("12", 8'h12);
      send_word(8'h34, 1'b0, 1'b1, 1'b0);
      expect_word("34", 8'h34);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Asynchronous reset mid-word, then a clean word.
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, i == 0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_busy", 32'(busy), 32'd0);
      check("async_sum", 32'(sum_out), 32'd0);
      check("async_valid", 32'(out_valid), 32'd0);
      model_reset();
      idle_inputs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send_word(8'hC3, 1'b0, 1'b0, 1'b0);
      expect_word("c3", 8'hC3);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Final carry on 0xFF.
      send_word(8'hFF, 1'b0, 1'b0, 1'b1);
      expect_word("ff", 8'hFF);
      check("ovf_held", 32'(ovf), OVF_EN ? 32'd1 : 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("ovf_frozen", 32'(ovf), OVF_EN ? 32'd1 : 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("ovf_cleared", 32'(ovf), 32'd0);

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         bit be;
         bit fs;
         be = ($urandom_range(0, 3) != 0);
         fs = be && ($urandom_range(0, 9) == 0);
         cyc(be, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), fs,
             ($urandom_range(0, 9) < 7));
      end

      cmp_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
